// File: rtl/run_splitter_2_pkg.sv
// run_splitter_2_pkg: shared types and constants for the run splitter.
//   W_DEF     default element width
//   tup_w()   tuple width (two elements) for a given element width
//   state_t   splitter FSM encoding (ST_DATA=0, ST_TERM=1)
package run_splitter_2_pkg;

  localparam int W_DEF = 32;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TERM = 1'b1
  } state_t;

  function automatic int tup_w(input int w);
    return 2 * w;
  endfunction

  // Run terminal for the default width; any width uses all zeros.
  localparam logic [2*W_DEF-1:0] TERMINAL = '0;

endpackage

// File: rtl/run_splitter_2_if.sv
// run_splitter_2_if: source-FIFO and merger-FIFO signals of the splitter.
//   i_item/i_empty/o_read          first-word-fall-through source FIFO
//   o_fifo_1/_write/i_fifo_1_full  merger input FIFO 1
//   o_fifo_2/_write/i_fifo_2_full  merger input FIFO 2
// master: the splitter side; slave: the FIFO side.
interface run_splitter_2_if
  import run_splitter_2_pkg::*;
#(
  parameter int W = W_DEF
);
  logic [tup_w(W)-1:0] i_item;
  logic                i_empty;
  logic                o_read;
  logic [tup_w(W)-1:0] o_fifo_1;
  logic                o_fifo_1_write;
  logic                i_fifo_1_full;
  logic [tup_w(W)-1:0] o_fifo_2;
  logic                o_fifo_2_write;
  logic                i_fifo_2_full;

  modport master (
    input  i_item, i_empty, i_fifo_1_full, i_fifo_2_full,
    output o_read, o_fifo_1, o_fifo_1_write, o_fifo_2, o_fifo_2_write
  );

  modport slave (
    output i_item, i_empty, i_fifo_1_full, i_fifo_2_full,
    input  o_read, o_fifo_1, o_fifo_1_write, o_fifo_2, o_fifo_2_write
  );
endinterface

// File: rtl/run_splitter_2.sv
// run_splitter_2: drains 2-wide tuples from a FWFT source FIFO and deals
// runs of RUN_LEN tuples alternately to two merger input FIFOs, closing
// each run with one all-zero terminal tuple.
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   bus          run_splitter_2_if.master (source + two merger FIFOs)
//   o_run_count  completed runs, wraps modulo 2^CNT_W
// Data and strobes are combinational from the source head; only the
// control state is registered.
module run_splitter_2
  import run_splitter_2_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int RUN_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  run_splitter_2_if.master  bus,
  output logic [CNT_W-1:0]  o_run_count
);

  localparam int              TW   = tup_w(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_LEN - 1);

  state_t           state, state_nxt;
  logic             sel, sel_nxt;
  logic [CNT_W-1:0] tup_cnt, tup_cnt_nxt;
  logic [CNT_W-1:0] run_cnt, run_cnt_nxt;

  logic                tgt_full;
  logic                rd;
  logic [1:0]          wr;
  logic [1:0][TW-1:0]  wdata;

  // Only the FIFO currently being filled can stall the block.
  assign tgt_full = sel ? bus.i_fifo_2_full : bus.i_fifo_1_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_DATA;
      sel     <= 1'b0;
      tup_cnt <= '0;
      run_cnt <= '0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      tup_cnt <= tup_cnt_nxt;
      run_cnt <= run_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    tup_cnt_nxt = tup_cnt;
    run_cnt_nxt = run_cnt;
    rd          = 1'b0;
    wr          = '0;
    wdata       = '0;
    case (state)
      ST_DATA: begin
        // The head tuple is presented even while stalled; the strobe
        // is what qualifies it.
        wdata[sel] = bus.i_item;
        if (!bus.i_empty && !tgt_full) begin
          rd      = 1'b1;
          wr[sel] = 1'b1;
          if (tup_cnt == LAST) begin
            tup_cnt_nxt = '0;
            state_nxt   = ST_TERM;
          end else begin
            tup_cnt_nxt = tup_cnt + CNT_W'(1);
          end
        end
      end
      ST_TERM: begin
        // wdata stays zero: that is the terminal tuple.
        if (!tgt_full) begin
          wr[sel]     = 1'b1;
          sel_nxt     = ~sel;
          run_cnt_nxt = run_cnt + CNT_W'(1);
          state_nxt   = ST_DATA;
        end
      end
      default: state_nxt = ST_DATA;
    endcase
    // Outputs are forced quiet during reset, before the state is known.
    if (!i_rst_n) begin
      rd    = 1'b0;
      wr    = '0;
      wdata = '0;
    end
  end

  assign bus.o_read         = rd;
  assign bus.o_fifo_1       = wdata[0];
  assign bus.o_fifo_1_write = wr[0];
  assign bus.o_fifo_2       = wdata[1];
  assign bus.o_fifo_2_write = wr[1];
  assign o_run_count        = i_rst_n ? run_cnt : '0;

endmodule

// File: tb/tb_run_splitter_2.sv
module tb_run_splitter_2;
  import run_splitter_2_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rc4, rc1;

  run_splitter_2_if #(.W(W)) b4 ();
  run_splitter_2_if #(.W(W)) b1 ();

  run_splitter_2 #(.W(W), .RUN_LEN(4), .CNT_W(16)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b4.master), .o_run_count(rc4));
  run_splitter_2 #(.W(W), .RUN_LEN(1), .CNT_W(16)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1.master), .o_run_count(rc1));

  int n_chk = 0, n_pass = 0, viol = 0;
  logic [63:0] src[$], q1[$], q2[$];
  logic last_rd, last_w1, last_w2;
  logic [63:0] e1[5], e2[5];

  function automatic logic [63:0] tup(input int a, input int b);
    return {32'(b), 32'(a)};
  endfunction

  task automatic idle_inputs();
    b4.i_item = '0; b4.i_empty = 1'b1; b4.i_fifo_1_full = 1'b0; b4.i_fifo_2_full = 1'b0;
    b1.i_item = '0; b1.i_empty = 1'b1; b1.i_fifo_1_full = 1'b0; b1.i_fifo_2_full = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    src.delete(); q1.delete(); q2.delete();
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock of the source/sink FIFO models around the chosen DUT.
  task automatic cyc(input bit use1, input bit e_f, input bit f1, input bit f2);
    logic rd, w1, w2;
    logic [63:0] d1, d2;
    logic emp;
    logic [63:0] itm;
    emp = e_f || (src.size() == 0);
    itm = (src.size() != 0) ? src[0] : 64'h0;
    if (use1) begin
      b1.i_item = itm; b1.i_empty = emp; b1.i_fifo_1_full = f1; b1.i_fifo_2_full = f2;
    end else begin
      b4.i_item = itm; b4.i_empty = emp; b4.i_fifo_1_full = f1; b4.i_fifo_2_full = f2;
    end
    #1;
    if (use1) begin
      rd = b1.o_read; w1 = b1.o_fifo_1_write; w2 = b1.o_fifo_2_write; d1 = b1.o_fifo_1; d2 = b1.o_fifo_2;
    end else begin
      rd = b4.o_read; w1 = b4.o_fifo_1_write; w2 = b4.o_fifo_2_write; d1 = b4.o_fifo_1; d2 = b4.o_fifo_2;
    end
    if (rd && emp) viol++;
    if (w1 && f1) viol++;
    if (w2 && f2) viol++;
    if (w1 && w2) viol++;
    if (d1 != 0 && d2 != 0) viol++;
    if ((w1 && d2 != 0) || (w2 && d1 != 0)) viol++;
    if (w1) q1.push_back(d1);
    if (w2) q2.push_back(d2);
    if (rd && src.size() != 0) void'(src.pop_front());
    last_rd = rd; last_w1 = w1; last_w2 = w2;
    @(posedge clk); #1;
  endtask

  task automatic load_stream(input int n);
    for (int k = 0; k < n; k++) src.push_back(tup(2*k + 1, 2*k + 2));
  endtask

  task automatic test_reset();
    idle_inputs();
    b4.i_item = tup(1, 2); b4.i_empty = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++; if (b4.o_read !== 1'b0) $display("FAIL reset_read got=%b exp=0", b4.o_read); else n_pass++;
    n_chk++; if ({b4.o_fifo_1_write, b4.o_fifo_2_write} !== 2'b00) $display("FAIL reset_wr got=%b exp=00", {b4.o_fifo_1_write, b4.o_fifo_2_write}); else n_pass++;
    n_chk++; if ({b4.o_fifo_1, b4.o_fifo_2} !== 128'h0) $display("FAIL reset_data got=%h exp=0", {b4.o_fifo_1, b4.o_fifo_2}); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (rc4 !== 16'd0) $display("FAIL reset_run_count got=%0d exp=0", rc4); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_chk++; if (b4.o_read !== 1'b1) $display("FAIL post_reset_read got=%b exp=1", b4.o_read); else n_pass++;
    n_chk++; if (b4.o_fifo_1 !== tup(1, 2) || b4.o_fifo_1_write !== 1'b1) $display("FAIL post_reset_fifo1 got=%h/%b exp=%h/1", b4.o_fifo_1, b4.o_fifo_1_write, tup(1, 2)); else n_pass++;
    n_chk++; if (b4.o_fifo_2 !== 64'h0 || b4.o_fifo_2_write !== 1'b0) $display("FAIL post_reset_fifo2 got=%h/%b exp=0/0", b4.o_fifo_2, b4.o_fifo_2_write); else n_pass++;
  endtask

  task automatic check_streams(input string tag);
    n_chk++; if (q1.size() != 5) $display("FAIL %s_q1_size got=%0d exp=5", tag, q1.size()); else n_pass++;
    n_chk++; if (q2.size() != 5) $display("FAIL %s_q2_size got=%0d exp=5", tag, q2.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i < q1.size()) begin
        n_chk++; if (q1[i] !== e1[i]) $display("FAIL %s_q1[%0d] got=%h exp=%h", tag, i, q1[i], e1[i]); else n_pass++;
      end
      if (i < q2.size()) begin
        n_chk++; if (q2[i] !== e2[i]) $display("FAIL %s_q2[%0d] got=%h exp=%h", tag, i, q2[i], e2[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_basic();
    apply_reset();
    load_stream(8);
    for (int c = 1; c <= 10; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_streams("basic");
    n_chk++; if (rc4 !== 16'd2) $display("FAIL basic_run_count got=%0d exp=2", rc4); else n_pass++;
  endtask

  task automatic test_fifo1_full();
    // read pattern for cycles 1..13: stall 2-4, terminals at 8 and 13
    logic [13:1] exp_rd = 13'b0_1111_0111_0001;
    apply_reset();
    load_stream(8);
    for (int c = 1; c <= 13; c++) begin
      cyc(1'b0, 1'b0, (c >= 2 && c <= 4), 1'b0);
      n_chk++; if (last_rd !== exp_rd[c]) $display("FAIL full1_read_c%0d got=%b exp=%b", c, last_rd, exp_rd[c]); else n_pass++;
    end
    check_streams("full1");
    n_chk++; if (rc4 !== 16'd2) $display("FAIL full1_run_count got=%0d exp=2", rc4); else n_pass++;
  endtask

  task automatic test_empty_pulse();
    apply_reset();
    load_stream(8);
    for (int c = 1; c <= 16; c++) cyc(1'b0, (c % 2 == 0), 1'b0, 1'b0);
    check_streams("empty");
    n_chk++; if (rc4 !== 16'd2) $display("FAIL empty_run_count got=%0d exp=2", rc4); else n_pass++;
  endtask

  task automatic test_run_len_1();
    logic [63:0] x1[2], x2[2];
    x1[0] = tup(5, 6); x1[1] = 64'h0;
    x2[0] = tup(7, 8); x2[1] = 64'h0;
    apply_reset();
    src.push_back(tup(5, 6)); src.push_back(tup(7, 8));
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      n_chk++; if ((last_w1 + last_w2) != 1) $display("FAIL rl1_strobes_c%0d got=%b%b exp=one", c, last_w1, last_w2); else n_pass++;
    end
    n_chk++; if (q1.size() != 2 || q2.size() != 2) $display("FAIL rl1_sizes got=%0d/%0d exp=2/2", q1.size(), q2.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      if (i < q1.size()) begin
        n_chk++; if (q1[i] !== x1[i]) $display("FAIL rl1_q1[%0d] got=%h exp=%h", i, q1[i], x1[i]); else n_pass++;
      end
      if (i < q2.size()) begin
        n_chk++; if (q2[i] !== x2[i]) $display("FAIL rl1_q2[%0d] got=%h exp=%h", i, q2[i], x2[i]); else n_pass++;
      end
    end
    n_chk++; if (rc1 !== 16'd2) $display("FAIL rl1_run_count got=%0d exp=2", rc1); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    load_stream(4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (last_rd !== 1'b0 || last_w1 !== 1'b0) $display("FAIL midrst_quiet got=%b%b exp=00", last_rd, last_w1); else n_pass++;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (last_w1 !== 1'b1 || last_w2 !== 1'b0) $display("FAIL midrst_target got=%b%b exp=10", last_w1, last_w2); else n_pass++;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // t2,t3 open a fresh run, so no terminal may appear yet
    n_chk++; if (q1.size() != 4 || q2.size() != 0) $display("FAIL midrst_sizes got=%0d/%0d exp=4/0", q1.size(), q2.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q1.size(); i++) begin
      n_chk++; if (q1[i] !== tup(2*i + 1, 2*i + 2)) $display("FAIL midrst_q1[%0d] got=%h exp=%h", i, q1[i], tup(2*i + 1, 2*i + 2)); else n_pass++;
    end
    n_chk++; if (rc4 !== 16'd0) $display("FAIL midrst_run_count got=%0d exp=0", rc4); else n_pass++;
  endtask

  task automatic test_term_stall_f2();
    apply_reset();
    load_stream(10);
    for (int c = 1; c <= 5; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // FIFO 1 full while filling FIFO 2 must not stall
    for (int c = 6; c <= 9; c++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      n_chk++; if (last_rd !== 1'b1 || last_w2 !== 1'b1) $display("FAIL nontgt_full_c%0d got=%b%b exp=11", c, last_rd, last_w2); else n_pass++;
    end
    for (int c = 10; c <= 12; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_chk++; if (last_rd !== 1'b0 || last_w2 !== 1'b0 || last_w1 !== 1'b0) $display("FAIL term_stall_c%0d got=%b%b%b exp=000", c, last_rd, last_w1, last_w2); else n_pass++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (last_w2 !== 1'b1 || last_rd !== 1'b0) $display("FAIL term_release got=%b%b exp=10", last_w2, last_rd); else n_pass++;
    n_chk++; if (q2.size() != 5 || q2[q2.size()-1] !== 64'h0) $display("FAIL term_value got_size=%0d exp=5 with zero tail", q2.size()); else n_pass++;
    n_chk++; if (rc4 !== 16'd2) $display("FAIL term_run_count got=%0d exp=2", rc4); else n_pass++;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (last_w1 !== 1'b1 || q1[q1.size()-1] !== tup(17, 18)) $display("FAIL term_next_run got=%b/%h exp=1/%h", last_w1, q1[q1.size()-1], tup(17, 18)); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      e1[k] = tup(2*k + 1, 2*k + 2);
      e2[k] = tup(2*k + 9, 2*k + 10);
    end
    e1[4] = 64'h0;
    e2[4] = 64'h0;
    idle_inputs();
    test_reset();
    test_basic();
    test_fifo1_full();
    test_empty_pulse();
    test_run_len_1();
    test_reset_mid_run();
    test_term_stall_f2();
    n_chk++; if (viol != 0) $display("FAIL protocol_violations got=%0d exp=0", viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
